// File: rtl/riscv_mem_arbiter_if.sv
// CPU/host request ports and RAM port of the shared program/data RAM arbiter.
// master = SOC side (requesters and RAM array), slave = arbiter.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [3:0]        cpu_wmask;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;

  logic              host_req;
  logic [31:0]       host_addr;
  logic [3:0]        host_wmask;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              host_done;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              addr_err;
  logic              busy;

  modport master (
    output cpu_req, cpu_addr, cpu_wmask, cpu_wdata,
    input  cpu_rdata, cpu_done,
    output host_req, host_addr, host_wmask, host_wdata,
    input  host_rdata, host_done,
    input  mem_en, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata,
    input  addr_err, busy
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wmask, cpu_wdata,
    output cpu_rdata, cpu_done,
    input  host_req, host_addr, host_wmask, host_wdata,
    output host_rdata, host_done,
    output mem_en, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata,
    output addr_err, busy
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter for the single-port RAM, fixed CPU priority with host starvation guard.
// One access per 3 cycles: grant edge -> mem strobe -> done pulse; requesters hold req until done.
module riscv_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input logic                clkd,
  input logic                RESET,
  riscv_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state, state_nxt;
  logic              owner_host;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lat_rd;
  logic              lat_err;

  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wmask_q;
  logic [31:0]       mem_wdata_q;

  logic              cpu_done_q, host_done_q, addr_err_q;
  logic [31:0]       cpu_rdata_q, host_rdata_q;

  logic              any_req;
  logic              grant_host;
  logic [31:0]       sel_addr;
  logic [3:0]        sel_wmask;
  logic [31:0]       sel_wdata;
  logic              sel_in_range;
  logic [31:0]       resp_data;
  logic              unused_bits;

  always_ff @(posedge clkd) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    any_req      = bus.cpu_req || bus.host_req;
    grant_host   = bus.host_req && (!bus.cpu_req || wait_cnt == WAIT_MAX);
    sel_addr     = grant_host ? bus.host_addr  : bus.cpu_addr;
    sel_wmask    = grant_host ? bus.host_wmask : bus.cpu_wmask;
    sel_wdata    = grant_host ? bus.host_wdata : bus.cpu_wdata;
    sel_in_range = (sel_addr[31:ADDR_W+2] == '0);
    resp_data    = (lat_rd && !lat_err) ? bus.mem_rdata : 32'd0;
  end

  // Byte-offset bits never reach the word-addressed RAM.
  assign unused_bits = ^sel_addr[1:0];

  always_ff @(posedge clkd) begin
    if (!RESET) begin
      owner_host   <= 1'b0;
      wait_cnt     <= '0;
      lat_rd       <= 1'b0;
      lat_err      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wmask_q  <= 4'd0;
      mem_wdata_q  <= 32'd0;
      cpu_done_q   <= 1'b0;
      host_done_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      host_rdata_q <= 32'd0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      cpu_done_q  <= 1'b0;
      host_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_host <= grant_host;
            lat_rd     <= (sel_wmask == 4'd0);
            lat_err    <= !sel_in_range;
            // host_req with a CPU grant implies both were requesting
            if (grant_host)
              wait_cnt <= '0;
            else if (bus.host_req && wait_cnt != WAIT_MAX)
              wait_cnt <= wait_cnt + 1'b1;
            if (sel_in_range) begin
              mem_en_q    <= 1'b1;
              mem_addr_q  <= sel_addr[ADDR_W+1:2];
              mem_wmask_q <= sel_wmask;
              mem_wdata_q <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          cpu_done_q  <= !owner_host;
          host_done_q <= owner_host;
          addr_err_q  <= lat_err;
        end
        RESP: begin
          if (owner_host) host_rdata_q <= resp_data;
          else            cpu_rdata_q  <= resp_data;
        end
        default: ;
      endcase
    end
  end

  // RAM data arrives during the done cycle, so it is forwarded then and held afterwards.
  assign bus.cpu_rdata  = cpu_done_q  ? resp_data : cpu_rdata_q;
  assign bus.host_rdata = host_done_q ? resp_data : host_rdata_q;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.host_done  = host_done_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.busy       = (state != IDLE);
endmodule
